// File: rtl/timer_pkg.sv
// Shared timing types for the time-entry, countdown and display blocks.
// Field widths, per-field limits, the timer state encoding and small helpers.
package timer_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [HR_W-1:0]  hours;
        logic [MIN_W-1:0] minutes;
        logic [SEC_W-1:0] seconds;
        logic [MS_W-1:0]  millis;
    } time_t;

    // True when every field of the time value is zero.
    function automatic logic time_is_zero(input time_t t);
        return (t.millis  == 10'd0) && (t.seconds == 6'd0) &&
               (t.minutes == 6'd0)  && (t.hours   == 5'd0);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler for countdown_timer.
// Counts 0..MS_DIV-1 while en is high, holds its value while en is low so a
// paused countdown resumes mid-millisecond, and is cleared by clr.
// tick is high for the single cycle in which the terminal count is reached.
module ms_tick_gen #(
    parameter int MS_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(MS_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             term_s;

    assign term_s = (cnt_r == TERM);
    assign tick   = en && !clr && term_s;

    // Prescaler counter: clear, wrap at terminal count, or hold when disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (term_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: captures a clamped ms/sec/min/hr value, counts it down in
// 1 ms steps, supports pause/resume and flags expiry on done_o.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- when defined, expiry
// reloads the last loaded value from a shadow register and keeps running,
// with done_o pulsing for one cycle per expiry.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MS_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic [MS_W-1:0]  ms_i,
    input  logic [SEC_W-1:0] sec_i,
    input  logic [MIN_W-1:0] min_i,
    input  logic [HR_W-1:0]  hr_i,
    output logic [MS_W-1:0]  ms_o,
    output logic [SEC_W-1:0] sec_o,
    output logic [MIN_W-1:0] min_o,
    output logic [HR_W-1:0]  hr_o,
    output logic             running_o,
    output logic             done_o
);

    state_t state_r;
    state_t state_next_s;
    time_t  count_r;
    time_t  count_next_s;
    time_t  clamped_s;
    time_t  dec_s;
    logic   count_zero_s;
    logic   dec_zero_s;
    logic   load_acc_s;
    logic   tick_s;
    logic   expire_s;
    logic   presc_en_s;
    logic   running_r;
    logic   done_r;
    logic   running_next_s;
    logic   done_next_s;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    time_t  shadow_r;
`endif

    // Load is honoured everywhere except while actively counting.
    assign load_acc_s   = load && (state_r != RUN);
    assign count_zero_s = time_is_zero(count_r);
    assign dec_zero_s   = time_is_zero(dec_s);
    assign expire_s     = tick_s && dec_zero_s;
    assign presc_en_s   = (state_r == RUN);

    ms_tick_gen #(
        .MS_DIV (MS_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en_s),
        .clr   (load_acc_s),
        .tick  (tick_s)
    );

    // Saturate each entered field to its legal maximum
    always_comb begin
        clamped_s         = '{default: 1'b0};
        clamped_s.millis  = (ms_i  > MS_MAX)  ? MS_MAX  : ms_i;
        clamped_s.seconds = (sec_i > SEC_MAX) ? SEC_MAX : sec_i;
        clamped_s.minutes = (min_i > MIN_MAX) ? MIN_MAX : min_i;
        clamped_s.hours   = (hr_i  > HR_MAX)  ? HR_MAX  : hr_i;
    end

    // One-millisecond decrement through the ms->sec->min->hr borrow chain;
    // a zero count stays at zero so the value can never wrap below 0.
    always_comb begin
        dec_s = count_r;
        if (count_zero_s) begin
            dec_s = count_r;
        end else if (count_r.millis != 10'd0) begin
            dec_s.millis = count_r.millis - 10'd1;
        end else begin
            dec_s.millis = MS_MAX;
            if (count_r.seconds != 6'd0) begin
                dec_s.seconds = count_r.seconds - 6'd1;
            end else begin
                dec_s.seconds = SEC_MAX;
                if (count_r.minutes != 6'd0) begin
                    dec_s.minutes = count_r.minutes - 6'd1;
                end else begin
                    dec_s.minutes = MIN_MAX;
                    dec_s.hours   = count_r.hours - 5'd1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: load outranks pause, pause outranks start; expiry
    // outranks pause while running.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, PAUSE: begin
                if (load) begin
                    state_next_s = IDLE;
                end else if (pause) begin
                    state_next_s = state_r;
                end else if (start) begin
                    state_next_s = count_zero_s ? DONE : RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (pause) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                end
`else
                if (expire_s) begin
                    state_next_s = DONE;
                end else if (pause) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                end
`endif
            end
            DONE: begin
                if (load) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM outputs, computed one cycle ahead so they can be registered
    always_comb begin
        running_next_s = (state_next_s == RUN);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        done_next_s    = (state_next_s == DONE) || expire_s;
`else
        done_next_s    = (state_next_s == DONE);
`endif
    end

    // Next count value: load, reload on expiry, or a 1 ms decrement on tick
    always_comb begin
        count_next_s = count_r;
        if (load_acc_s) begin
            count_next_s = clamped_s;
        end else if (tick_s) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (dec_zero_s) begin
                count_next_s = shadow_r;
            end else begin
                count_next_s = dec_s;
            end
`else
            count_next_s = dec_s;
`endif
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and status output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= '{default: 1'b0};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            running_r <= running_next_s;
            done_r    <= done_next_s;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Shadow copy of the last loaded value, used as the reload source
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= '{default: 1'b0};
        end else if (load_acc_s) begin
            shadow_r <= clamped_s;
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

    assign ms_o      = count_r.millis;
    assign sec_o     = count_r.seconds;
    assign min_o     = count_r.minutes;
    assign hr_o      = count_r.hours;
    assign running_o = running_r;
    assign done_o    = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (MS_DIV = 4). The reference model
// keeps the remaining time as a single millisecond total and derives the
// displayed fields by division; the auto-reload test runs only when
// COUNTDOWN_AUTO_RELOAD_EN is defined.
`timescale 1ns/1ps
module tb_countdown_timer;

    localparam int MS_DIV = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       start;
    logic       pause;
    logic [9:0] ms_i;
    logic [5:0] sec_i;
    logic [5:0] min_i;
    logic [4:0] hr_i;
    logic [9:0] ms_o;
    logic [5:0] sec_o;
    logic [5:0] min_o;
    logic [4:0] hr_o;
    logic       running_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_total;
    int m_shadow;
    int m_phase;
    int m_state;
    bit m_pulse;

    countdown_timer #(.MS_DIV(MS_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .start     (start),
        .pause     (pause),
        .ms_i      (ms_i),
        .sec_i     (sec_i),
        .min_i     (min_i),
        .hr_i      (hr_i),
        .ms_o      (ms_o),
        .sec_o     (sec_o),
        .min_o     (min_o),
        .hr_o      (hr_o),
        .running_o (running_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        m_total  = 0;
        m_shadow = 0;
        m_phase  = 0;
        m_state  = S_IDLE;
        m_pulse  = 1'b0;
    endfunction

    // One clock of the behavioural model, using the inputs the DUT samples.
    function automatic void model_step();
        m_pulse = 1'b0;
        if (m_state == S_RUN) begin
            if (m_phase == MS_DIV - 1) begin
                m_phase = 0;
                m_total = m_total - 1;
                if (m_total == 0) begin
                    if (AUTO) begin
                        m_total = m_shadow;
                        m_pulse = 1'b1;
                    end else begin
                        m_state = S_DONE;
                    end
                end
            end else begin
                m_phase = m_phase + 1;
            end
            if (m_state == S_RUN && pause) m_state = S_PAUSE;
        end else if (load) begin
            m_total = clampi(int'(ms_i), 999) + 1000 * clampi(int'(sec_i), 59)
                    + 60000 * clampi(int'(min_i), 59) + 3600000 * clampi(int'(hr_i), 23);
            m_shadow = m_total;
            m_phase  = 0;
            m_state  = S_IDLE;
        end else if (!pause && start && (m_state == S_IDLE || m_state == S_PAUSE)) begin
            m_state = (m_total == 0) ? S_DONE : S_RUN;
        end
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [9:0] e_ms;
        logic [5:0] e_sec;
        logic [5:0] e_min;
        logic [4:0] e_hr;
        e_ms  = 10'(m_total % 1000);
        e_sec = 6'((m_total / 1000) % 60);
        e_min = 6'((m_total / 60000) % 60);
        e_hr  = 5'(m_total / 3600000);
        return {e_ms, e_sec, e_min, e_hr, 1'(m_state == S_RUN),
                1'((m_state == S_DONE) || m_pulse)};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {ms_o, sec_o, min_o, hr_o, running_o, done_o};
    endfunction

    task automatic set_time(input int ms, input int s, input int m, input int h);
        ms_i  = 10'(ms);
        sec_i = 6'(s);
        min_i = 6'(m);
        hr_i  = 5'(h);
    endtask

    // Apply controls for one clock, advance the model, return at the negedge.
    task automatic drive_cycle(input logic l, input logic s, input logic p);
        load  = l;
        start = s;
        pause = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        set_time(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== 29'd0) begin
            failures++;
            $display("FAIL reset: got %h expected 0", dut_vec());
        end
        reset = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== 29'd0) begin
            failures++;
            $display("FAIL reset_release: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_clamp();
        set_time(1010, 63, 60, 31);
        drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if ({ms_o, sec_o, min_o, hr_o, running_o, done_o} !==
            {10'd999, 6'd59, 6'd59, 5'd23, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clamp: got %0d/%0d/%0d/%0d run=%0d done=%0d expected 999/59/59/23 run=0 done=0",
                     ms_o, sec_o, min_o, hr_o, running_o, done_o);
        end
    endtask

    task automatic test_borrow();
        drive_cycle(1'b0, 1'b0, 1'b1);
        set_time(0, 0, 1, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ms_o, sec_o, min_o, hr_o, running_o} !== {10'd999, 6'd59, 6'd0, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL borrow_first: got %0d/%0d/%0d/%0d run=%0d expected 999/59/0/0 run=1",
                     ms_o, sec_o, min_o, hr_o, running_o);
        end
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ms_o, sec_o, min_o, hr_o} !== {10'd998, 6'd59, 6'd0, 5'd0}) begin
            failures++;
            $display("FAIL borrow_second: got %0d/%0d/%0d/%0d expected 998/59/0/0",
                     ms_o, sec_o, min_o, hr_o);
        end
    endtask

    task automatic test_expiry();
        drive_cycle(1'b0, 1'b0, 1'b1);
        set_time(3, 0, 0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        repeat (11) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ms_o, running_o, done_o} !== {10'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL expiry_before: got ms=%0d run=%0d done=%0d expected ms=1 run=1 done=0",
                     ms_o, running_o, done_o);
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ms_o, running_o, done_o} !== {10'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL expiry_done: got ms=%0d run=%0d done=%0d expected ms=0 run=0 done=1",
                     ms_o, running_o, done_o);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({ms_o, running_o, done_o} !== {10'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL expiry_start_ignored: got ms=%0d run=%0d done=%0d expected ms=0 run=0 done=1",
                     ms_o, running_o, done_o);
        end
    endtask

    task automatic test_pause();
        drive_cycle(1'b0, 1'b0, 1'b1);
        set_time(10, 0, 0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        repeat (5) drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if ({ms_o, running_o, done_o} !== {10'd9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL pause_enter: got ms=%0d run=%0d done=%0d expected ms=9 run=0 done=0",
                     ms_o, running_o, done_o);
        end
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ms_o, running_o} !== {10'd9, 1'b0}) begin
            failures++;
            $display("FAIL pause_hold: got ms=%0d run=%0d expected ms=9 run=0", ms_o, running_o);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ms_o, running_o} !== {10'd9, 1'b1}) begin
            failures++;
            $display("FAIL pause_resume_early: got ms=%0d run=%0d expected ms=9 run=1", ms_o, running_o);
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (ms_o !== 10'd8) begin
            failures++;
            $display("FAIL pause_resume: got ms=%0d expected 8", ms_o);
        end
    endtask

    task automatic test_zero_start();
        drive_cycle(1'b0, 1'b0, 1'b1);
        set_time(0, 0, 0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({ms_o, running_o, done_o} !== {10'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL zero_start: got ms=%0d run=%0d done=%0d expected ms=0 run=0 done=1",
                     ms_o, running_o, done_o);
        end
        set_time(5, 0, 0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if ({ms_o, running_o, done_o} !== {10'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL zero_reload: got ms=%0d run=%0d done=%0d expected ms=5 run=0 done=0",
                     ms_o, running_o, done_o);
        end
    endtask

    task automatic test_auto_reload();
        drive_cycle(1'b0, 1'b0, 1'b1);
        set_time(2, 0, 0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 24; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if ({running_o, done_o} !== {1'b1, 1'((c % 8) == 0)}) begin
                failures++;
                $display("FAIL auto_reload cycle %0d: got run=%0d done=%0d expected run=1 done=%0d",
                         c, running_o, done_o, ((c % 8) == 0));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drive_cycle(1'b0, 1'b0, 1'b1);
        set_time(500, 2, 0, 0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        repeat (7) drive_cycle(1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 29'd0) begin
            failures++;
            $display("FAIL reset_mid_run: got %h expected 0", dut_vec());
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 3000; i++) begin
            logic l;
            logic s;
            logic p;
            r = int'($urandom_range(0, 99));
            l = (r < 8);
            s = (r >= 8 && r < 28) || (r == 95);
            p = (r >= 90);
            if (l) begin
                if ($urandom_range(0, 9) < 7) begin
                    set_time(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 0, 0);
                end else begin
                    set_time(int'($urandom_range(0, 1023)), int'($urandom_range(0, 63)),
                             int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
                end
            end
            drive_cycle(l, s, p);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic check_model_sync(input string name);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL model_sync_%s: got %h expected %h", name, dut_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_clamp();
        check_model_sync("clamp");
        test_borrow();
        check_model_sync("borrow");
        if (!AUTO) begin
            test_expiry();
            check_model_sync("expiry");
        end
        test_pause();
        check_model_sync("pause");
        test_zero_start();
        check_model_sync("zero_start");
        if (AUTO) begin
            test_auto_reload();
            check_model_sync("auto_reload");
        end
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
